hd44780_bus_sequencer: RTL and testbench

// - Owns the HD44780 8-bit parallel bus: runs the power-on init sequence, then accepts byte writes
//   (RS + data) over a valid/ready handshake and drives RS/E/DB with correct setup, pulse and exec delays.
// - Replaces free-running slow-clock strobing of the LCD; all timing comes from an internal 1-us tick on clkIn.

---
 rtl/hd44780_pkg.sv | 65 ++++++
 rtl/hd44780_tick_gen.sv | 28 ++
 rtl/hd44780_bus_sequencer.sv | 158 +++++++++++++++
 tb/tb_hd44780_bus_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/hd44780_pkg.sv
// Shared types and constants for the HD44780 bus sequencer.
// Holds the FSM state encoding, the power-on init ROM (byte + delay class),
// the LCD command opcodes and the default tick constants.
package hd44780_pkg;

    // Default timing, in ticks, assuming a 50 MHz clock and a 1 us tick.
    localparam int DEF_TICK_CYCLES = 50;
    localparam int DEF_POWERUP_TK  = 40000;
    localparam int DEF_CMD_TK      = 40;
    localparam int DEF_LONG_TK     = 1600;
    localparam int DEF_INIT2_TK    = 4100;
    // Wait after the second 0x30 of the init sequence. This value is fixed
    // by the controller datasheet and does not scale with the other delays.
    localparam int INIT3_TK        = 100;

    localparam logic [7:0] CMD_CLEAR       = 8'h01;
    localparam logic [7:0] CMD_HOME        = 8'h02;
    localparam logic [7:0] CMD_ENTRY_INC   = 8'h06;
    localparam logic [7:0] CMD_DISP_OFF    = 8'h08;
    localparam logic [7:0] CMD_DISP_ON     = 8'h0C;
    localparam logic [7:0] CMD_FUNC_8B     = 8'h30;
    localparam logic [7:0] CMD_FUNC_8B_2L  = 8'h38;

    typedef enum logic [2:0] {
        PWR_WAIT, LOAD, SETUP, E_HIGH, HOLD, EXEC, IDLE
    } state_t;

    // Delay classes. The top module maps each class to a tick count, so the
    // ROM stays independent of the timing parameters.
    typedef enum logic [1:0] {
        DLY_CMD, DLY_LONG, DLY_INIT2, DLY_INIT3
    } dly_sel_t;

    typedef struct packed {
        logic [7:0] dat;
        dly_sel_t   sel;
    } init_entry_t;

    localparam int INIT_LEN = 8;

    function automatic init_entry_t init_rom(input logic [2:0] idx);
        init_entry_t e;
        case (idx)
            3'd0:    e = '{dat: CMD_FUNC_8B,    sel: DLY_INIT2};
            3'd1:    e = '{dat: CMD_FUNC_8B,    sel: DLY_INIT3};
            3'd2:    e = '{dat: CMD_FUNC_8B,    sel: DLY_CMD};
            3'd3:    e = '{dat: CMD_FUNC_8B_2L, sel: DLY_CMD};
            3'd4:    e = '{dat: CMD_DISP_OFF,   sel: DLY_CMD};
            3'd5:    e = '{dat: CMD_CLEAR,      sel: DLY_LONG};
            3'd6:    e = '{dat: CMD_ENTRY_INC,  sel: DLY_CMD};
            default: e = '{dat: CMD_DISP_ON,    sel: DLY_CMD};
        endcase
        return e;
    endfunction

    // Clear (0x01) and Return Home (0x02/0x03) need the long execution time.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] dat);
        return !rs && ((dat[7:1] == 7'b0000001) || (dat == CMD_CLEAR));
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hd44780_tick_gen.sv
// Timing prescaler: emits a one-cycle tick every TICK_CYCLES clocks.
// Latency: first tick TICK_CYCLES-1 cycles after a restart; restart is synchronous.
// No backpressure; the tick is a free-running pulse. Ports: clk, rst_n, restart, tick.
module hd44780_tick_gen #(
    parameter int TICK_CYCLES = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);
    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    logic [PW-1:0] cnt;

    assign tick = (cnt == PW'(TICK_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PW'(1);
        end
    end

endmodule

// File: rtl/hd44780_bus_sequencer.sv
// HD44780 8-bit bus owner: power-on init sequence, then single byte writes with timed E strobe.
// Latency: lcdRs/lcdData one cycle after accept, E after 1 tick, ready again after (3+delay) ticks.
// Backpressure: wrReady low during init and while a write is in flight; requests then are dropped.
// Ports: clkIn/rstN, write handshake (wrValid, wrReady, wrRs, wrData), LCD bus (lcdRs, lcdRw, lcdE, lcdData), initDone.
module hd44780_bus_sequencer
    import hd44780_pkg::*;
#(
    parameter int TICK_CYCLES = DEF_TICK_CYCLES,
    parameter int POWERUP_TK  = DEF_POWERUP_TK,
    parameter int CMD_TK      = DEF_CMD_TK,
    parameter int LONG_TK     = DEF_LONG_TK,
    parameter int INIT2_TK    = DEF_INIT2_TK
) (
    input  logic       clkIn,
    input  logic       rstN,
    input  logic       wrValid,
    output logic       wrReady,
    input  logic       wrRs,
    input  logic [7:0] wrData,
    output logic       lcdRs,
    output logic       lcdRw,
    output logic       lcdE,
    output logic [7:0] lcdData,
    output logic       initDone
);
    // Sized for the largest delay in use, so the fixed 100-tick init wait
    // never wraps even when the power-up delay is scaled down.
    localparam int MAX_TK = max_int(max_int(POWERUP_TK, INIT2_TK),
                                    max_int(max_int(LONG_TK, CMD_TK), INIT3_TK));
    localparam int DW = $clog2(MAX_TK + 1);
    typedef logic [DW-1:0] dly_t;

    function automatic dly_t sel_ticks(input dly_sel_t s);
        case (s)
            DLY_LONG:  return dly_t'(LONG_TK);
            DLY_INIT2: return dly_t'(INIT2_TK);
            DLY_INIT3: return dly_t'(INIT3_TK);
            default:   return dly_t'(CMD_TK);
        endcase
    endfunction

    state_t      state, state_nxt;
    dly_t        dly, dly_nxt;
    dly_t        exec_dly, exec_dly_nxt;
    logic [2:0]  idx, idx_nxt;
    logic        rs_q, rs_nxt;
    logic [7:0]  dat_q, dat_nxt;
    logic        done_q, done_nxt;
    logic        e_q, rdy_q;
    logic        tick, timed, phase_end, accept;
    init_entry_t rom_e;

    // Restart the prescaler on every state change so each phase lasts
    // exactly n whole ticks from its first cycle.
    hd44780_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
        .clk     (clkIn),
        .rst_n   (rstN),
        .restart (state_nxt != state),
        .tick    (tick)
    );

    assign rom_e     = init_rom(idx);
    assign timed     = (state == PWR_WAIT) || (state == SETUP) || (state == E_HIGH) ||
                       (state == HOLD) || (state == EXEC);
    assign phase_end = timed && tick && (dly == dly_t'(1));
    // rdy_q is high exactly when the FSM sits in IDLE.
    assign accept    = wrValid && rdy_q;

    always_comb begin
        state_nxt    = state;
        dly_nxt      = dly;
        exec_dly_nxt = exec_dly;
        idx_nxt      = idx;
        rs_nxt       = rs_q;
        dat_nxt      = dat_q;
        done_nxt     = done_q;

        if (timed && tick && !phase_end) begin
            dly_nxt = dly - dly_t'(1);
        end

        case (state)
            PWR_WAIT: if (phase_end) state_nxt = LOAD;
            LOAD: begin
                rs_nxt       = 1'b0;
                dat_nxt      = rom_e.dat;
                exec_dly_nxt = sel_ticks(rom_e.sel);
                dly_nxt      = dly_t'(1);
                state_nxt    = SETUP;
            end
            SETUP: if (phase_end) begin
                dly_nxt   = dly_t'(1);
                state_nxt = E_HIGH;
            end
            E_HIGH: if (phase_end) begin
                dly_nxt   = dly_t'(1);
                state_nxt = HOLD;
            end
            HOLD: if (phase_end) begin
                dly_nxt   = exec_dly;
                state_nxt = EXEC;
            end
            EXEC: if (phase_end) begin
                if (done_q) begin
                    state_nxt = IDLE;
                end else if (idx == 3'(INIT_LEN - 1)) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    idx_nxt   = idx + 3'd1;
                    state_nxt = LOAD;
                end
            end
            IDLE: if (accept) begin
                rs_nxt       = wrRs;
                dat_nxt      = wrData;
                exec_dly_nxt = is_long_cmd(wrRs, wrData) ? dly_t'(LONG_TK) : dly_t'(CMD_TK);
                dly_nxt      = dly_t'(1);
                state_nxt    = SETUP;
            end
            default: state_nxt = PWR_WAIT;
        endcase
    end

    always_ff @(posedge clkIn or negedge rstN) begin
        if (!rstN) begin
            state    <= PWR_WAIT;
            dly      <= dly_t'(POWERUP_TK);
            exec_dly <= '0;
            idx      <= '0;
            rs_q     <= 1'b0;
            dat_q    <= '0;
            done_q   <= 1'b0;
            e_q      <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            dly      <= dly_nxt;
            exec_dly <= exec_dly_nxt;
            idx      <= idx_nxt;
            rs_q     <= rs_nxt;
            dat_q    <= dat_nxt;
            done_q   <= done_nxt;
            // Strobe and ready are decoded from the next state so they are
            // registered yet line up with the phase they belong to.
            e_q      <= (state_nxt == E_HIGH);
            rdy_q    <= (state_nxt == IDLE);
        end
    end

    assign lcdRs    = rs_q;
    assign lcdRw    = 1'b0;
    assign lcdE     = e_q;
    assign lcdData  = dat_q;
    assign wrReady  = rdy_q;
    assign initDone = done_q;

endmodule

// File: tb/tb_hd44780_bus_sequencer.sv
// Directed bench for hd44780_bus_sequencer with short timing parameters.
// Cycle numbers count posedges after reset release (or after the accepting edge).
// Outputs are sampled 1 time unit after each rising edge.
module tb_hd44780_bus_sequencer;

    logic       clkIn = 1'b0;
    logic       rstN;
    logic       wrValid;
    logic       wrReady;
    logic       wrRs;
    logic [7:0] wrData;
    logic       lcdRs;
    logic       lcdRw;
    logic       lcdE;
    logic [7:0] lcdData;
    logic       initDone;

    hd44780_bus_sequencer #(
        .TICK_CYCLES (2),
        .POWERUP_TK  (10),
        .CMD_TK      (4),
        .LONG_TK     (8),
        .INIT2_TK    (6)
    ) dut (
        .clkIn    (clkIn),
        .rstN     (rstN),
        .wrValid  (wrValid),
        .wrReady  (wrReady),
        .wrRs     (wrRs),
        .wrData   (wrData),
        .lcdRs    (lcdRs),
        .lcdRw    (lcdRw),
        .lcdE     (lcdE),
        .lcdData  (lcdData),
        .initDone (initDone)
    );

    always #5 clkIn = ~clkIn;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    logic e_prev = 1'b0;
    int   rise_q[$];
    int   fall_q[$];
    logic [7:0] rdat_q[$];
    logic       rrs_q[$];

    // Hand-computed for the bench parameters: E rises at edge 23, then each
    // write adds 7 + 2*delay cycles (delays 6,100,4,4,4,8,4,4); the last
    // EXEC ends 4 + 8 cycles after the final rise.
    int         exp_rise [8] = '{23, 42, 249, 264, 279, 294, 317, 332};
    logic [7:0] exp_dat  [8] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clkIn);
        #1;
        cyc++;
        if (lcdE && !e_prev) begin
            rise_q.push_back(cyc);
            rdat_q.push_back(lcdData);
            rrs_q.push_back(lcdRs);
        end
        if (!lcdE && e_prev) fall_q.push_back(cyc);
        e_prev = lcdE;
    endtask

    task automatic clear_log();
        rise_q.delete();
        fall_q.delete();
        rdat_q.delete();
        rrs_q.delete();
    endtask

    task automatic check_init();
        clear_log();
        e_prev = 1'b0;
        @(negedge clkIn);
        rstN = 1'b1;
        cyc  = 0;
        while (!initDone && cyc < 1000) begin
            step();
            // A request during init must be dropped.
            if (cyc == 100) begin
                wrValid = 1'b1; wrRs = 1'b1; wrData = 8'hFF;
            end
            if (cyc == 106) wrValid = 1'b0;
        end
        chk("init_done_cyc", 32'(cyc), 32'd344);
        chk("init_rdy", 32'(wrReady), 32'd1);
        chk("init_npulse", 32'(rise_q.size()), 32'd8);
        chk("init_nfall", 32'(fall_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < rise_q.size()) begin
                chk($sformatf("init_rise%0d", i), 32'(rise_q[i]), 32'(exp_rise[i]));
                chk($sformatf("init_dat%0d", i), 32'(rdat_q[i]), 32'(exp_dat[i]));
                chk($sformatf("init_rs%0d", i), 32'(rrs_q[i]), 32'd0);
            end
            if (i < fall_q.size())
                chk($sformatf("init_fall%0d", i), 32'(fall_q[i]), 32'(exp_rise[i] + 2));
        end
    endtask

    // Single write with a stray request during EXEC; lat counts cycles from
    // the accepting edge to wrReady high again.
    task automatic do_write(input logic rs, input logic [7:0] dat, input int lat, input string tag);
        int t0;
        clear_log();
        wrValid = 1'b1; wrRs = rs; wrData = dat;
        step();
        t0 = cyc;
        wrValid = 1'b0; wrData = 8'hA5;
        chk({tag, "_rdy_drop"}, 32'(wrReady), 32'd0);
        chk({tag, "_rs"}, 32'(lcdRs), 32'(rs));
        chk({tag, "_dat"}, 32'(lcdData), 32'(dat));
        repeat (6) step();
        wrValid = 1'b1; wrRs = ~rs; wrData = ~dat;
        step();
        wrValid = 1'b0;
        while (!wrReady && (cyc - t0) < 100) step();
        chk({tag, "_lat"}, 32'(cyc - t0), 32'(lat));
        chk({tag, "_npulse"}, 32'(rise_q.size()), 32'd1);
        chk({tag, "_rise"}, 32'(rise_q.size() > 0 ? rise_q[0] - t0 : -1), 32'd2);
        chk({tag, "_fall"}, 32'(fall_q.size() > 0 ? fall_q[0] - t0 : -1), 32'd4);
        chk({tag, "_hold_dat"}, 32'(lcdData), 32'(dat));
        chk({tag, "_hold_rs"}, 32'(lcdRs), 32'(rs));
    endtask

    initial begin
        int t0, t1;
        rstN = 1'b0; wrValid = 1'b0; wrRs = 1'b0; wrData = 8'h00;
        #23;
        chk("rst_e", 32'(lcdE), 32'd0);
        chk("rst_rs", 32'(lcdRs), 32'd0);
        chk("rst_rw", 32'(lcdRw), 32'd0);
        chk("rst_dat", 32'(lcdData), 32'd0);
        chk("rst_rdy", 32'(wrReady), 32'd0);
        chk("rst_done", 32'(initDone), 32'd0);

        check_init();

        do_write(1'b1, 8'h41, 14, "data41");
        do_write(1'b0, 8'h01, 22, "clear");
        do_write(1'b0, 8'h03, 22, "home3");
        do_write(1'b0, 8'h02, 22, "home2");
        do_write(1'b1, 8'h01, 14, "data01");
        do_write(1'b0, 8'h04, 14, "cmd04");
        do_write(1'b0, 8'h00, 14, "cmd00");

        // Back-to-back: wrValid held high across two bytes.
        clear_log();
        wrValid = 1'b1; wrRs = 1'b1; wrData = 8'h55;
        step();
        t0 = cyc;
        wrData = 8'hAA;
        while (!wrReady && (cyc - t0) < 100) step();
        chk("b2b_first_lat", 32'(cyc - t0), 32'd14);
        step();
        t1 = cyc;
        wrValid = 1'b0;
        chk("b2b_gap", 32'(t1 - t0), 32'd15);
        chk("b2b_rdy_drop", 32'(wrReady), 32'd0);
        chk("b2b_dat2", 32'(lcdData), 32'h AA);
        while (!wrReady && (cyc - t1) < 100) step();
        chk("b2b_second_lat", 32'(cyc - t1), 32'd14);
        chk("b2b_npulse", 32'(rise_q.size()), 32'd2);
        chk("b2b_rise2", 32'(rise_q.size() > 1 ? rise_q[1] - t0 : -1), 32'd17);

        // Reset while E is high.
        wrValid = 1'b1; wrRs = 1'b1; wrData = 8'h7E;
        step();
        wrValid = 1'b0;
        step();
        step();
        chk("mid_e_high", 32'(lcdE), 32'd1);
        rstN = 1'b0;
        #1;
        chk("mid_rst_e", 32'(lcdE), 32'd0);
        chk("mid_rst_done", 32'(initDone), 32'd0);
        chk("mid_rst_rdy", 32'(wrReady), 32'd0);
        chk("mid_rst_dat", 32'(lcdData), 32'd0);
        repeat (3) @(posedge clkIn);

        check_init();
        do_write(1'b1, 8'h5A, 14, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
